// File: rtl/card_vga_pkg.sv
// Shared timing defaults, colour type and palette for the card-grid VGA renderer.
package card_vga_pkg;

   localparam int H_ACTIVE = 640;
   localparam int H_FP     = 16;
   localparam int H_SYNC   = 96;
   localparam int H_BP     = 48;
   localparam int V_ACTIVE = 480;
   localparam int V_FP     = 10;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 33;
   localparam int CELL_W   = 160;
   localparam int CELL_H   = 120;
   localparam int BORDER   = 4;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   localparam rgb_t BLACK         = 24'h000000;
   localparam rgb_t BORDER_GRAY   = 24'h404040;
   localparam rgb_t CURSOR_YELLOW = 24'hFFFF00;
   localparam rgb_t BACK_BLUE     = 24'h0000C0;

   localparam rgb_t PALETTE [8] = '{
      24'hFF0000, 24'h00FF00, 24'h00FFFF, 24'hFF00FF,
      24'hFF8000, 24'hFFFFFF, 24'h8000FF, 24'hFF80C0
   };

endpackage

// File: rtl/card_grid_renderer_if.sv
// Video output bundle: syncs, blank, RGB and the per-frame snapshot strobe.
interface card_grid_renderer_if;

   logic       hsync;
   logic       vsync;
   logic       blank_n;
   logic [7:0] red;
   logic [7:0] green;
   logic [7:0] blue;
   logic       frame_start;

   modport master (output hsync, vsync, blank_n, red, green, blue, frame_start);
   modport slave  (input  hsync, vsync, blank_n, red, green, blue, frame_start);

endinterface

// File: rtl/vga_timing_gen.sv
// Free-running h/v pixel counters with raw syncs, visible flag and a registered end-of-frame strobe.
module vga_timing_gen #(
   parameter int H_ACTIVE = card_vga_pkg::H_ACTIVE,
   parameter int H_FP     = card_vga_pkg::H_FP,
   parameter int H_SYNC   = card_vga_pkg::H_SYNC,
   parameter int H_BP     = card_vga_pkg::H_BP,
   parameter int V_ACTIVE = card_vga_pkg::V_ACTIVE,
   parameter int V_FP     = card_vga_pkg::V_FP,
   parameter int V_SYNC   = card_vga_pkg::V_SYNC,
   parameter int V_BP     = card_vga_pkg::V_BP
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [9:0] h,
   output logic [9:0] v,
   output logic       visible,
   output logic       hsync_raw,
   output logic       vsync_raw,
   output logic       frame_end
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] H_PRE  = 10'(H_TOTAL - 2);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
   localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
   localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

   // frame_end is set one step early so it is high exactly while the counters hold the last pixel
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h         <= '0;
         v         <= '0;
         frame_end <= 1'b0;
      end else begin
         frame_end <= (h == H_PRE) && (v == V_LAST);
         if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + 10'd1;
         end else begin
            h <= h + 10'd1;
         end
      end
   end

   assign visible   = (h < H_VIS) && (v < V_VIS);
   assign hsync_raw = !((h >= HS_BEG) && (h <= HS_END));
   assign vsync_raw = !((v >= VS_BEG) && (v <= VS_END));

endmodule

// File: rtl/card_grid_renderer.sv
// Renders a 4x4 card board as VGA video from per-frame shadow copies of the game state.
module card_grid_renderer #(
   parameter int H_ACTIVE = card_vga_pkg::H_ACTIVE,
   parameter int H_FP     = card_vga_pkg::H_FP,
   parameter int H_SYNC   = card_vga_pkg::H_SYNC,
   parameter int H_BP     = card_vga_pkg::H_BP,
   parameter int V_ACTIVE = card_vga_pkg::V_ACTIVE,
   parameter int V_FP     = card_vga_pkg::V_FP,
   parameter int V_SYNC   = card_vga_pkg::V_SYNC,
   parameter int V_BP     = card_vga_pkg::V_BP,
   parameter int CELL_W   = card_vga_pkg::CELL_W,
   parameter int CELL_H   = card_vga_pkg::CELL_H,
   parameter int BORDER   = card_vga_pkg::BORDER
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [15:0]                 card_up,
   input  logic [47:0]                 card_id,
   input  logic [1:0]                  cursor_row,
   input  logic [1:0]                  cursor_col,
   card_grid_renderer_if.master        vid
);
   import card_vga_pkg::*;

   localparam logic [9:0] X1 = 10'(CELL_W);
   localparam logic [9:0] X2 = 10'(2 * CELL_W);
   localparam logic [9:0] X3 = 10'(3 * CELL_W);
   localparam logic [9:0] Y1 = 10'(CELL_H);
   localparam logic [9:0] Y2 = 10'(2 * CELL_H);
   localparam logic [9:0] Y3 = 10'(3 * CELL_H);
   localparam logic [9:0] B     = 10'(BORDER);
   localparam logic [9:0] HX_IN = 10'(CELL_W - BORDER);
   localparam logic [9:0] VY_IN = 10'(CELL_H - BORDER);

   function automatic rgb_t pixel_colour(input logic vld, input logic border, input logic cursor_hit,
                                         input logic face_up, input logic [2:0] val);
      if (!vld)                     return BLACK;
      else if (border && cursor_hit) return CURSOR_YELLOW;
      else if (border)              return BORDER_GRAY;
      else if (!face_up)            return BACK_BLUE;
      else                          return PALETTE[val];
   endfunction

   logic [9:0]  h, v, hx, vy;
   logic        visible, hsync_raw, vsync_raw, frame_end;
   logic [1:0]  col_c, row_c;
   logic        border_c;
   logic [15:0] up_sh;
   logic [47:0] id_sh;
   logic [1:0]  crow_sh, ccol_sh;
   logic [1:0]  col_p1, row_p1;
   logic        border_p1, vld_p1, hs_p1, vs_p1;
   logic [3:0]  k;
   logic [5:0]  id_base;
   rgb_t        colour_c;

   vga_timing_gen #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
   ) u_timing (
      .clk(clk), .rst_n(rst_n), .h(h), .v(v), .visible(visible),
      .hsync_raw(hsync_raw), .vsync_raw(vsync_raw), .frame_end(frame_end)
   );

   // Snapshot on the last pixel of the frame so the whole next frame renders one consistent state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         up_sh   <= '0;
         id_sh   <= '0;
         crow_sh <= '0;
         ccol_sh <= '0;
      end else if (frame_end) begin
         up_sh   <= card_up;
         id_sh   <= card_id;
         crow_sh <= cursor_row;
         ccol_sh <= cursor_col;
      end
   end

   always_comb begin
      col_c = 2'd0;
      hx    = h;
      if      (h >= X3) begin col_c = 2'd3; hx = h - X3; end
      else if (h >= X2) begin col_c = 2'd2; hx = h - X2; end
      else if (h >= X1) begin col_c = 2'd1; hx = h - X1; end
      row_c = 2'd0;
      vy    = v;
      if      (v >= Y3) begin row_c = 2'd3; vy = v - Y3; end
      else if (v >= Y2) begin row_c = 2'd2; vy = v - Y2; end
      else if (v >= Y1) begin row_c = 2'd1; vy = v - Y1; end
      border_c = (hx < B) || (hx >= HX_IN) || (vy < B) || (vy >= VY_IN);
   end

   // Stage 1: cell position, border, visible and raw syncs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_p1    <= '0;
         row_p1    <= '0;
         border_p1 <= 1'b0;
         vld_p1    <= 1'b0;
         hs_p1     <= 1'b1;
         vs_p1     <= 1'b1;
      end else begin
         col_p1    <= col_c;
         row_p1    <= row_c;
         border_p1 <= border_c;
         vld_p1    <= visible;
         hs_p1     <= hsync_raw;
         vs_p1     <= vsync_raw;
      end
   end

   assign k       = {row_p1, col_p1};
   assign id_base = 6'(k) * 6'd3;

   always_comb begin
      colour_c = pixel_colour(vld_p1, border_p1, (row_p1 == crow_sh) && (col_p1 == ccol_sh),
                              up_sh[k], id_sh[id_base +: 3]);
   end

   // Stage 2: registered video outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vid.red     <= '0;
         vid.green   <= '0;
         vid.blue    <= '0;
         vid.blank_n <= 1'b0;
         vid.hsync   <= 1'b1;
         vid.vsync   <= 1'b1;
      end else begin
         vid.red     <= colour_c.r;
         vid.green   <= colour_c.g;
         vid.blue    <= colour_c.b;
         vid.blank_n <= vld_p1;
         vid.hsync   <= hs_p1;
         vid.vsync   <= vs_p1;
      end
   end

   assign vid.frame_start = frame_end;

endmodule

// File: tb/tb_card_grid_renderer.sv
// Scoreboard bench for card_grid_renderer on a scaled-down raster (80x39 total, 16x8 cells).
module tb_card_grid_renderer;

   localparam int HA = 64, HF = 4, HS = 8, HB = 4, HT = HA + HF + HS + HB;
   localparam int VA = 32, VF = 2, VS = 2, VB = 3, VT = VA + VF + VS + VB;
   localparam int FT = HT * VT;
   localparam int CW = 16, CH = 8, BW = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] card_up;
   logic [47:0] card_id;
   logic [1:0]  cursor_row, cursor_col;

   card_grid_renderer_if vid();

   card_grid_renderer #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .CELL_W(CW), .CELL_H(CH), .BORDER(BW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .card_up(card_up), .card_id(card_id),
      .cursor_row(cursor_row), .cursor_col(cursor_col), .vid(vid)
   );

   always #20 clk = ~clk;

   typedef struct {
      int          p;
      logic        blank;
      logic        hs;
      logic        vs;
      logic [23:0] rgb;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0, n_pass = 0;
   int   edges = 0, pulses = 0, hs_low = 0, vs_low = 0;
   bit   hv_done = 0, hs_prev = 1, hs_seen = 0;

   task automatic check(input string name, input logic [47:0] act, input logic [47:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, req);
   endtask

   // p is the pixel index counted from reset release; output for pixel p is visible after edge p+2
   task automatic push(input string name, input int f, input int h, input int v,
                       input logic blank, input logic hs, input logic vs, input logic [23:0] rgb);
      exp_t e;
      e.p = f * FT + v * HT + h;
      e.blank = blank; e.hs = hs; e.vs = vs; e.rgb = rgb; e.name = name;
      exp_q.push_back(e);
   endtask

   task automatic wait_edges(input int target, input string name);
      int g = 0;
      while (edges < target && g < 4 * FT) begin
         @(negedge clk);
         g++;
      end
      check({"wait_", name}, edges, target);
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) edges = 0;
      else        edges++;
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (vid.frame_start) begin
            pulses++;
            check("frame_start_phase", edges % FT, FT - 1);
         end
         if (hs_prev && !vid.hsync && !hs_seen) begin
            hs_seen = 1;
            check("first_hsync_fall", edges, HA + HF + 2);
         end
         hs_prev = vid.hsync;
         if (!hv_done && edges >= 2 && edges <= FT + 1) begin
            if (!vid.hsync) hs_low++;
            if (!vid.vsync) vs_low++;
            if (edges == FT + 1) begin
               hv_done = 1;
               check("hsync_low_per_frame", hs_low, HS * VT);
               check("vsync_low_per_frame", vs_low, VS * HT);
            end
         end
         while (exp_q.size() > 0 && exp_q[0].p < edges - 2) begin
            e = exp_q.pop_front();
            n_checks++;
            $display("FAIL %s: pixel %0d never presented, now at %0d", e.name, e.p, edges - 2);
         end
         if (exp_q.size() > 0 && exp_q[0].p == edges - 2) begin
            e = exp_q.pop_front();
            check(e.name, {vid.blank_n, vid.hsync, vid.vsync, vid.red, vid.green, vid.blue},
                  {e.blank, e.hs, e.vs, e.rgb});
         end
      end else begin
         hs_prev = 1;
         hs_seen = 0;
      end
   end

   initial begin
      rst_n = 1'b0;
      card_up = '0; card_id = '0; cursor_row = '0; cursor_col = '0;
      repeat (3) @(negedge clk);
      check("rst_syncs", {vid.hsync, vid.vsync}, 2'b11);
      check("rst_blank_rgb", {vid.blank_n, vid.red, vid.green, vid.blue}, 25'h0);
      check("rst_frame_start", vid.frame_start, 1'b0);

      // Applied before release: frame 0 still renders defaults, frame 1 shows this state
      card_up    = 16'h0020;
      card_id    = (48'd3 << 15) | (48'd6 << 36);
      cursor_row = 2'd1;
      cursor_col = 2'd2;

      push("f0_cursor_border", 0,  1,  1, 1, 1, 1, 24'hFFFF00);
      push("f0_gray_border",   0, 17,  1, 1, 1, 1, 24'h404040);
      push("f0_hblank",        0, 70,  2, 0, 0, 1, 24'h000000);
      push("f0_back_00",       0,  8,  4, 1, 1, 1, 24'h0000C0);
      push("f0_border_12",     0, 33,  9, 1, 1, 1, 24'h404040);
      push("f0_card5_down",    0, 24, 12, 1, 1, 1, 24'h0000C0);
      push("f0_vblank",        0,  5, 34, 0, 1, 0, 24'h000000);
      push("f1_old_cursor",    1,  1,  1, 1, 1, 1, 24'h404040);
      push("f1_back_00",       1,  8,  4, 1, 1, 1, 24'h0000C0);
      push("f1_cell_corner",   1, 16,  8, 1, 1, 1, 24'h404040);
      push("f1_new_cursor",    1, 33,  9, 1, 1, 1, 24'hFFFF00);
      push("f1_card5_up",      1, 24, 12, 1, 1, 1, 24'hFF00FF);
      push("f1_card12_torn",   1,  8, 28, 1, 1, 1, 24'h0000C0);
      push("f2_card5_up",      2, 24, 12, 1, 1, 1, 24'hFF00FF);
      push("f2_card12_up",     2,  8, 28, 1, 1, 1, 24'h8000FF);
      push("f3_before_reset",  3,  8, 20, 1, 1, 1, 24'h0000C0);

      @(negedge clk);
      rst_n = 1'b1;

      wait_edges(FT + 20 * HT, "tear_point");
      card_up[12] = 1'b1;

      wait_edges(3 * FT + 20 * HT + 11, "midframe_point");
      check("queue_drained_run1", exp_q.size(), 0);
      rst_n = 1'b0;
      #1;
      check("midrst_syncs", {vid.hsync, vid.vsync}, 2'b11);
      check("midrst_blank_rgb", {vid.blank_n, vid.red, vid.green, vid.blue}, 25'h0);
      check("midrst_frame_start", vid.frame_start, 1'b0);

      repeat (3) @(negedge clk);
      push("r0_card5_cleared",  0, 24, 12, 1, 1, 1, 24'h0000C0);
      push("r0_card12_cleared", 0,  8, 28, 1, 1, 1, 24'h0000C0);
      rst_n = 1'b1;

      wait_edges(FT + 2, "post_reset_frame");
      check("frame_start_count", pulses, 4);
      check("queue_drained_run2", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
